attack_sequencer: RTL

ATTACK_SEQUENCER -- requirements
Module: attack_sequencer

---
 rtl/fighter_pkg.sv | 17 +
 rtl/btn_edge_det.sv | 38 +++
 rtl/attack_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fighter_pkg.sv
// Shared fighter-game definitions: attack phase encoding and small helpers.
package fighter_pkg;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_STARTUP  = 2'd1,
    PH_ACTIVE   = 2'd2,
    PH_RECOVERY = 2'd3
  } phase_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Frame-rate rising-edge detector for the attack button.
// A press is only reported after the button has been seen low at least once
// since reset, so a button held through reset release is not a press.
module btn_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic scen,
  input  logic btn,
  output logic press
);

  logic prev_q, prev_d;
  logic armed_q, armed_d;

  // Sample the button level once per frame; arm on the first low sample.
  always_comb begin
    prev_d  = prev_q;
    armed_d = armed_q;
    if (scen) begin
      prev_d = btn;
      if (!btn) armed_d = 1'b1;
    end
  end

  // History registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign press = scen & btn & ~prev_q & armed_q;

endmodule

// File: rtl/attack_sequencer.sv
// Attack sequencer: IDLE -> STARTUP -> ACTIVE -> RECOVERY -> IDLE, timed in
// frames (SCEN ticks). Getting hit aborts any attack; a landed hit ends the
// active window early so each swing hits at most once.
// Optional macro ATTACK_BUFFER_EN: a press late in RECOVERY is buffered and
// chains straight into the next STARTUP.
module attack_sequencer
  import fighter_pkg::*;
#(
  parameter int STARTUP_FRAMES  = 4,
  parameter int ACTIVE_FRAMES   = 3,
  parameter int RECOVERY_FRAMES = 8,
  parameter int BUFFER_FRAMES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCEN,
  input  logic       atk_btn,
  input  logic       hitstun_active,
  input  logic       hit_event,
  input  logic       hit_confirm,
  output logic       attack_active,
  output logic       attack_start,
  output logic [1:0] phase,
  output logic       busy
);

  localparam int MAXF  = max3(STARTUP_FRAMES, ACTIVE_FRAMES, RECOVERY_FRAMES);
  localparam int CNT_W = (MAXF > 1) ? $clog2(MAXF) : 1;
  localparam logic [CNT_W-1:0] S_LOAD = CNT_W'(STARTUP_FRAMES - 1);
  localparam logic [CNT_W-1:0] A_LOAD = CNT_W'(ACTIVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(RECOVERY_FRAMES - 1);

  // Reject illegal frame counts at elaboration.
  if (STARTUP_FRAMES < 1 || ACTIVE_FRAMES < 1 || RECOVERY_FRAMES < 1 ||
      BUFFER_FRAMES < 1 || BUFFER_FRAMES > RECOVERY_FRAMES) begin : g_bad_cfg
    $error("attack_sequencer: illegal frame parameters");
  end

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             landed_q, landed_d;
  logic             start_q, start_d;
  logic             press;

  btn_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .scen  (SCEN),
    .btn   (atk_btn),
    .press (press)
  );

`ifdef ATTACK_BUFFER_EN
  logic buf_q, buf_d;
  logic buf_take;
  // Buffered request: already latched, or a legal press inside the window now.
  assign buf_take = buf_q | (press & ~hitstun_active &
                             (int'(cnt_q) < BUFFER_FRAMES));
`endif

  // Next-state logic; nothing moves without a frame tick.
  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    landed_d = landed_q;
    start_d  = 1'b0;
`ifdef ATTACK_BUFFER_EN
    buf_d    = buf_q;
`endif
    if (SCEN) begin
      if (hit_event && phase_q != PH_IDLE) begin
        // Being hit cancels everything in flight.
        phase_d  = PH_IDLE;
        cnt_d    = '0;
        landed_d = 1'b0;
`ifdef ATTACK_BUFFER_EN
        buf_d    = 1'b0;
`endif
      end else begin
        case (phase_q)
          PH_IDLE: begin
            if (press && !hitstun_active && !hit_event) begin
              phase_d  = PH_STARTUP;
              cnt_d    = S_LOAD;
              landed_d = 1'b0;
              start_d  = 1'b1;
            end
          end
          PH_STARTUP: begin
            if (cnt_q == '0) begin
              phase_d = PH_ACTIVE;
              cnt_d   = A_LOAD;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          PH_ACTIVE: begin
            if (hit_confirm) begin
              landed_d = 1'b1;
              phase_d  = PH_RECOVERY;
              cnt_d    = R_LOAD;
            end else if (cnt_q == '0) begin
              phase_d = PH_RECOVERY;
              cnt_d   = R_LOAD;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          PH_RECOVERY: begin
            if (cnt_q == '0) begin
`ifdef ATTACK_BUFFER_EN
              buf_d = 1'b0;
              if (buf_take && !hitstun_active) begin
                phase_d  = PH_STARTUP;
                cnt_d    = S_LOAD;
                landed_d = 1'b0;
                start_d  = 1'b1;
              end else begin
                phase_d = PH_IDLE;
              end
`else
              phase_d = PH_IDLE;
`endif
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
`ifdef ATTACK_BUFFER_EN
              buf_d = buf_take;
`endif
            end
          end
          default: phase_d = PH_IDLE;
        endcase
      end
    end
  end

  // State registers, cleared asynchronously (also mid-attack).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q  <= PH_IDLE;
      cnt_q    <= '0;
      landed_q <= 1'b0;
      start_q  <= 1'b0;
`ifdef ATTACK_BUFFER_EN
      buf_q    <= 1'b0;
`endif
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      landed_q <= landed_d;
      start_q  <= start_d;
`ifdef ATTACK_BUFFER_EN
      buf_q    <= buf_d;
`endif
    end
  end

  assign attack_active = (phase_q == PH_ACTIVE) && !landed_q;
  assign attack_start  = start_q;
  assign phase         = phase_q;
  assign busy          = (phase_q != PH_IDLE);

endmodule
